// File: rtl/cpu_mem_arbiter.sv
// Two-port round-robin arbiter with optional burst lock in front of the
// single-port CPU_MEM packet buffer (registered inputs, negedge write/read).
module cpu_mem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk0,
  input  logic                  rst_n,

  input  logic                  p0_req,
  input  logic                  p0_lock,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,

  input  logic                  p1_req,
  input  logic                  p1_lock,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,

  output logic                  mem_csb0,
  output logic                  mem_web0,
  output logic [ADDR_WIDTH-1:0] mem_addr0,
  output logic [DATA_WIDTH-1:0] mem_din0,
  input  logic [DATA_WIDTH-1:0] mem_dout0
);

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_P0   = 2'd1,
    LOCK_P1   = 2'd2
  } lock_e;

  lock_e lock_owner;
  logic  last_gnt;     // 0 = port 0 granted last, 1 = port 1
  logic  rd_pending;
  logic  rd_port;

  logic  p0_held;
  logic  p1_held;
  logic  any_gnt;
  lock_e lock_next;

  // A lock only holds while its owner keeps both req and lock high.
  assign p0_held = (lock_owner == LOCK_P0) && p0_req && p0_lock;
  assign p1_held = (lock_owner == LOCK_P1) && p1_req && p1_lock;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    // Grants are suppressed while in reset so the memory sees idle inputs.
    if (rst_n) begin
      if (p0_req && p1_req) begin
        if (p0_held)       p0_gnt = 1'b1;
        else if (p1_held)  p1_gnt = 1'b1;
        else if (last_gnt) p0_gnt = 1'b1;
        else               p1_gnt = 1'b1;
      end else begin
        p0_gnt = p0_req;
        p1_gnt = p1_req;
      end
    end
  end

  assign any_gnt = p0_gnt | p1_gnt;

  always_comb begin
    mem_csb0  = 1'b1;
    mem_web0  = 1'b1;
    mem_addr0 = '0;
    mem_din0  = '0;
    if (p0_gnt) begin
      mem_csb0  = 1'b0;
      mem_web0  = ~p0_we;
      mem_addr0 = p0_addr;
      mem_din0  = p0_wdata;
    end else if (p1_gnt) begin
      mem_csb0  = 1'b0;
      mem_web0  = ~p1_we;
      mem_addr0 = p1_addr;
      mem_din0  = p1_wdata;
    end
  end

  // A held lock always results in a locked grant to its owner, so the next
  // owner is simply whoever was granted with lock asserted this cycle.
  always_comb begin
    lock_next = LOCK_NONE;
    if (p0_gnt && p0_lock)      lock_next = LOCK_P0;
    else if (p1_gnt && p1_lock) lock_next = LOCK_P1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt   <= 1'b1;
      lock_owner <= LOCK_NONE;
      rd_pending <= 1'b0;
      rd_port    <= 1'b0;
    end else begin
      if (any_gnt) last_gnt <= p1_gnt;
      lock_owner <= lock_next;
      rd_pending <= (p0_gnt && !p0_we) || (p1_gnt && !p1_we);
      rd_port    <= p1_gnt;
    end
  end

  // Memory output settles at the negedge inside the valid cycle.
  assign p0_rvalid = rd_pending && !rd_port;
  assign p1_rvalid = rd_pending &&  rd_port;
  assign p0_rdata  = p0_rvalid ? mem_dout0 : '0;
  assign p1_rdata  = p1_rvalid ? mem_dout0 : '0;

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
Two-requester arbiter in front of the single-port CPU_MEM packet buffer (128 x 8, registered inputs, negedge write/read).
- Port 0: CPU loader (writes packets, occasional readback).
- Port 1: UPDI frame builder (reads packet bytes to form command frames).
- Grants one memory access per clock, round-robin on contention, with an optional lock for burst transfers.
- Drives the memory's csb0/web0/addr0/din0 and returns read data with a valid strobe to the requester that owns it.

Parameters:
DATA_WIDTH, 8, memory word width
ADDR_WIDTH, 7, memory address width (128 words)

Ports:
clk0  in  1  clock; same clock as CPU_MEM clk0
rst_n  in  1  asynchronous active-low reset
p0_req  in  1  port 0 access request, level, held until granted
p0_lock  in  1  port 0 keeps ownership while req and lock are both high
p0_we  in  1  port 0 write when 1, read when 0
p0_addr  in  ADDR_WIDTH  port 0 address
p0_wdata  in  DATA_WIDTH  port 0 write data
p0_gnt  out  1  port 0 access accepted this cycle (combinational)
p0_rvalid  out  1  port 0 read data valid this cycle
p0_rdata  out  DATA_WIDTH  port 0 read data
p1_req, p1_lock, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata  as port 0, for port 1
mem_csb0  out  1  memory chip select, active low
mem_web0  out  1  memory write enable, active low
mem_addr0  out  ADDR_WIDTH  memory address
mem_din0  out  DATA_WIDTH  memory write data
mem_dout0  in  DATA_WIDTH  memory read data

Behaviour:
- Arbitration: combinational within the cycle. A grant means the access is captured by the memory at the next posedge clk0.
  - Only one req high: that port is granted.
  - Both high: the owner is granted if lock_owner is set. Otherwise the port that was not granted last is granted.
  - At most one gnt high per cycle.
- State registers:
  - last_gnt: reset value 1, so port 0 wins the first contention.
  - lock_owner: none / p0 / p1.
  - rd_pending, rd_port.
- Lock:
  - Set to port x on a grant to x while px_lock=1.
  - Cleared in any cycle where px_req=0 or px_lock=0.
  - After lock release under contention, the other port wins the next cycle.
- Memory drive (combinational from the winner):
  - mem_csb0=0, mem_web0=~we, mem_addr0=addr, mem_din0=wdata.
  - No grant: mem_csb0=1, mem_web0=1, mem_addr0=0, mem_din0=0.
- Read path:
  - A read granted in cycle T is sampled by the memory at the posedge ending T. mem_dout0 updates at the following negedge.
  - px_rvalid=1 during cycle T+1 only (registered flag set at that posedge). px_rdata = mem_dout0 while valid, 0 otherwise.
  - Latency is 1 cycle. Back-to-back reads give one rvalid per cycle.
- Writes produce no rvalid. A read granted one cycle after a write to the same address returns the new data, because the memory's negedge write precedes its negedge read.
- Requester rules: req/we/addr/wdata must be stable while req=1 and gnt=0. Dropping req before grant cancels the request silently.
- Reset (asynchronous, any time):
  - last_gnt=1, lock_owner=none, rd_pending=0.
  - All px_rvalid/px_rdata=0.
  - Memory outputs go to the idle values.
  - An access already captured by the memory may still complete. After reset deassertion, no rvalid is issued for it.

Test Plan:
- Reset, then p0 writes 0xA5 to addr 0x10, p1 reads 0x10 next cycle -> p1_gnt in that cycle, p1_rvalid=1 one cycle later with p1_rdata=0xA5, p0_rvalid stays 0.
- Both req high for 4 cycles, no lock, reads of addrs 1 (p0) and 2 (p1) -> grants alternate p0,p1,p0,p1; every rvalid goes to the correct port with the correct data.
- p1 lock burst: p1_req=p1_lock=1 reading addrs 0..7 while p0_req=1 -> p1 granted 8 consecutive cycles with rdata matching preloaded bytes; p0 granted the cycle after p1_lock drops.
- Idle: no requests for 10 cycles -> mem_csb0=1 and mem_web0=1 throughout, no rvalid.
- Assert rst_n low mid-cycle one cycle after a p0 read grant -> p0_rvalid=0 immediately and memory outputs idle; after release, first contention is won by p0.
- p0 drops req before grant during p1 lock -> no p0 access occurs, memory content unchanged.
